// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding
// Contents:
//   UART_CLK_DIV_38400  bit period in clk cycles at 48 MHz / 38400 baud
//   UART_ST_*           2-bit state codes, also used by the receiver
//   uart_state_t        enum built on those codes
package uart_pkg;

    localparam int UART_CLK_DIV_38400 = 1250;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = UART_ST_IDLE,
        ST_START = UART_ST_START,
        ST_DATA  = UART_ST_DATA,
        ST_STOP  = UART_ST_STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request and data; ignored when full
//   pop, pop_data   read request; pop_data shows the head entry combinationally
//   count           entries held (0..DEPTH)
//   empty           count == 0
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_en;
    logic             pop_en;

    // Full/empty come only from the registered count, so a pop in the same
    // cycle never makes room for a push.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1/8N2 UART transmitter, LSB first
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_data, wr_valid   byte offered by producer
//   wr_ready            FIFO not full; byte taken when wr_valid && wr_ready
//   tx                  registered serial line, idle high
//   busy                high from start bit to end of last stop bit
//   fifo_count          bytes waiting, not counting the one being sent
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV_38400,
    parameter int DEPTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEPTH) + 1;

    uart_state_t    state, state_n;
    logic [BW-1:0]  baud_cnt, baud_cnt_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift, shift_n;
    logic           fifo_pop;
    logic [7:0]     fifo_data;
    logic           fifo_empty;
    logic           baud_last;
    logic           tx_d;
    logic           busy_d;

    assign wr_ready  = (fifo_count != CW'(DEPTH));
    assign baud_last = (baud_cnt == BW'(CLK_DIV - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_valid && wr_ready),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            tx       <= tx_d;
            busy     <= busy_d;
        end
    end

    // tx and busy are registered from the current state, so the line lags
    // the FSM by one cycle: pop at N+1, start bit visible from N+2.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state != ST_IDLE);
        case (state)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_cnt_n = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_n   = fifo_data;
                    bit_cnt_n = '0;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = ST_DATA;
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
                        state_n   = ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            ST_STOP: begin
                // bit_cnt counts stop bits here; the next queued byte goes
                // straight to START so back-to-back frames have no gap.
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_n  = fifo_data;
                            state_n  = ST_START;
                        end else begin
                            state_n  = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       tx1;
    logic       busy1;
    logic [2:0] fifo_count;
    logic [7:0] wr2_data;
    logic       wr2_valid;
    logic       wr2_ready;
    logic       tx2;
    logic       busy2;
    logic [2:0] fifo_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DEPTH(4), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx1),
        .busy       (busy1),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.CLK_DIV(4), .DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr2_data),
        .wr_valid   (wr2_valid),
        .wr_ready   (wr2_ready),
        .tx         (tx2),
        .busy       (busy2),
        .fifo_count (fifo_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    // Called one ns after the edge where the start bit appears; returns one ns
    // after the edge ending the last stop bit. Samples each bit at its start.
    task automatic frame(input bit sel, input logic [7:0] b, input int sb, input string tag);
        logic [7:0] rx;
        logic       t;
        rx = '0;
        for (int k = 0; k < 9 + sb; k++) begin
            t = sel ? tx2 : tx1;
            chk($sformatf("%s_bit%0d", tag, k), 32'(t), 32'(exp_bit(b, k)));
            chk($sformatf("%s_busy%0d", tag, k), 32'(sel ? busy2 : busy1), 32'd1);
            if (k >= 1 && k <= 8) rx[k-1] = t;
            repeat (4) tick();
        end
        chk($sformatf("%s_rx", tag), 32'(rx), 32'(b));
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_data   = 8'h00;
        wr_valid  = 1'b0;
        wr2_data  = 8'h00;
        wr2_valid = 1'b0;
        repeat (2) tick();
        chk("rst_tx", 32'(tx1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_tx2", 32'(tx2), 32'd1);
        chk("rst_ready2", 32'(wr2_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: single byte 0x41
        wr_data = 8'h41; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("t1_count_push", 32'(fifo_count), 32'd1);
        chk("t1_tx_n", 32'(tx1), 32'd1);
        tick();
        chk("t1_count_pop", 32'(fifo_count), 32'd0);
        chk("t1_tx_n1", 32'(tx1), 32'd1);
        chk("t1_busy_n1", 32'(busy1), 32'd0);
        tick();
        frame(1'b0, 8'h41, 1, "t1");
        chk("t1_end_busy", 32'(busy1), 32'd0);
        chk("t1_end_tx", 32'(tx1), 32'd1);
        repeat (3) tick();

        // 2: back-to-back 0x55, 0xAA
        wr_data = 8'h55; wr_valid = 1'b1;
        tick();
        chk("t2_count_a", 32'(fifo_count), 32'd1);
        wr_data = 8'hAA;
        tick();
        wr_valid = 1'b0;
        chk("t2_count_b", 32'(fifo_count), 32'd1);
        tick();
        chk("t2_count_c", 32'(fifo_count), 32'd1);
        frame(1'b0, 8'h55, 1, "t2a");
        chk("t2_count_after_pop", 32'(fifo_count), 32'd0);
        frame(1'b0, 8'hAA, 1, "t2b");
        chk("t2_end_busy", 32'(busy1), 32'd0);
        chk("t2_end_tx", 32'(tx1), 32'd1);
        repeat (3) tick();

        // 3 + 4: hold wr_valid over 6 bytes, then full push/pop collision
        wr_valid = 1'b1;
        wr_data = 8'h10; tick();
        chk("t3_count_e1", 32'(fifo_count), 32'd1);
        wr_data = 8'h11; tick();
        chk("t3_count_e2", 32'(fifo_count), 32'd1);
        wr_data = 8'h12; tick();
        chk("t3_count_e3", 32'(fifo_count), 32'd2);
        chk("t3_start_b0", 32'(tx1), 32'd0);
        wr_data = 8'h13; tick();
        chk("t3_count_e4", 32'(fifo_count), 32'd3);
        wr_data = 8'h14; tick();
        chk("t3_count_e5", 32'(fifo_count), 32'd4);
        chk("t3_ready_full", 32'(wr_ready), 32'd0);
        wr_data = 8'h15;
        for (int e = 6; e <= 41; e++) begin
            tick();
            if ((e - 3) % 4 == 0) begin
                chk($sformatf("t3_b0_bit%0d", (e - 3) / 4), 32'(tx1), 32'(exp_bit(8'h10, (e - 3) / 4)));
            end
        end
        chk("t3_count_held", 32'(fifo_count), 32'd4);
        chk("t3_ready_held", 32'(wr_ready), 32'd0);
        tick();
        chk("t4_count_collide", 32'(fifo_count), 32'd3);
        chk("t4_ready_after", 32'(wr_ready), 32'd1);
        chk("t4_tx_stop", 32'(tx1), 32'd1);
        tick();
        wr_valid = 1'b0;
        chk("t4_count_refill", 32'(fifo_count), 32'd4);
        frame(1'b0, 8'h11, 1, "t3b1");
        frame(1'b0, 8'h12, 1, "t3b2");
        frame(1'b0, 8'h13, 1, "t3b3");
        frame(1'b0, 8'h14, 1, "t3b4");
        frame(1'b0, 8'h15, 1, "t3b5");
        chk("t3_end_busy", 32'(busy1), 32'd0);
        chk("t3_end_count", 32'(fifo_count), 32'd0);
        repeat (3) tick();

        // 5: reset in the middle of DATA
        wr_valid = 1'b1;
        wr_data = 8'h00; tick();
        wr_data = 8'h33; tick();
        wr_valid = 1'b0;
        repeat (11) tick();
        chk("t5_tx_data", 32'(tx1), 32'd0);
        chk("t5_count_pre", 32'(fifo_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_tx_rst", 32'(tx1), 32'd1);
        chk("t5_busy_rst", 32'(busy1), 32'd0);
        chk("t5_count_rst", 32'(fifo_count), 32'd0);
        chk("t5_ready_rst", 32'(wr_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("t5_quiet_tx", 32'(tx1), 32'd1);
            chk("t5_quiet_busy", 32'(busy1), 32'd0);
        end

        // 6: two stop bits, 0xFF
        wr2_data = 8'hFF; wr2_valid = 1'b1;
        tick();
        wr2_valid = 1'b0;
        chk("t6_count", 32'(fifo_count2), 32'd1);
        tick();
        chk("t6_tx_n1", 32'(tx2), 32'd1);
        tick();
        frame(1'b1, 8'hFF, 2, "t6");
        chk("t6_end_busy", 32'(busy2), 32'd0);
        chk("t6_end_tx", 32'(tx2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
